// File: rtl/bounce_gen_multi_if.sv
// Purpose : bundles the stimulus/response signals of the multi-channel bounce generator.
// Latency : n/a (wires only).
// Backpressure: none; all signals are level-valued, sampled every clock.
//
// Ports (per modport):
//   master : drives en, sig_in; observes bounce_out, busy (stimulus side / testbench)
//   slave  : receives en, sig_in; drives bounce_out, busy (bounce generator)
interface bounce_gen_multi_if #(
  parameter int NUM_CH = 4
);
  logic              en;          // 1 = bounce mode, 0 = registered pass-through
  logic [NUM_CH-1:0] sig_in;      // clean inputs, synchronous to clk
  logic [NUM_CH-1:0] bounce_out;  // bouncy outputs, registered
  logic [NUM_CH-1:0] busy;        // channel is mid-bounce

  modport master (
    output en,
    output sig_in,
    input  bounce_out,
    input  busy
  );

  modport slave (
    input  en,
    input  sig_in,
    output bounce_out,
    output busy
  );
endinterface

// File: rtl/bounce_gen_multi.sv
// Purpose : per-channel switch-bounce generator; each sig_in edge becomes 2N-1 output
//           edges of pseudo-random segment length, ending on the new value.
// Latency : 1 clock detect/pass-through; settling = sum of segment lengths; no backpressure.
//
// Ports:
//   clk  : system clock
//   rst  : asynchronous, active-high reset
//   bg   : slave modport of bounce_gen_multi_if (en, sig_in in; bounce_out, busy out)
module bounce_gen_multi #(
  parameter int          NUM_CH          = 4,
  parameter int          MIN_BOUNCE_CLKS = 5000,
  parameter int          RAND_BITS       = 14,
  parameter int          NUM_BOUNCES_MIN = 2,
  parameter int          NB_RAND_BITS    = 2,
  parameter logic [15:0] SEED            = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst,
  bounce_gen_multi_if.slave  bg
);

  // Counter holds D-1, with D up to MIN_BOUNCE_CLKS + 2^RAND_BITS - 1.
  localparam int CW = $clog2(MIN_BOUNCE_CLKS + 2**RAND_BITS) + 1;
  // Remaining-rising-edge count holds up to NUM_BOUNCES_MIN + 2^NB_RAND_BITS - 1.
  localparam int NW = $clog2(NUM_BOUNCES_MIN + 2**NB_RAND_BITS) + 1;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_AWAY,    // output sits at ~target
    ST_TOWARD   // output sits at target, more bounces still to come
  } state_e;

  state_e            state_q [NUM_CH];
  state_e            state_d [NUM_CH];
  logic [15:0]       lfsr_q  [NUM_CH];
  logic [15:0]       lfsr_d  [NUM_CH];
  logic [CW-1:0]     cnt_q   [NUM_CH];
  logic [CW-1:0]     cnt_d   [NUM_CH];
  logic [NW-1:0]     rem_q   [NUM_CH];
  logic [NW-1:0]     rem_d   [NUM_CH];
  logic [CW-1:0]     seg_ld  [NUM_CH];   // D-1 drawn from the current LFSR state
  logic [NW-1:0]     nb_ld   [NUM_CH];   // N drawn from the current LFSR state
  logic [NUM_CH-1:0] tgt_q, tgt_d;
  logic [NUM_CH-1:0] bounce_q, bounce_d;
  logic [NUM_CH-1:0] busy_w;

  // Channel seeds differ by index so simultaneous edges produce distinct sequences;
  // an all-zero state would lock the LFSR up, so it is replaced by 1.
  function automatic logic [15:0] seed_of(input int ch);
    logic [15:0] s;
    s = SEED + 16'(ch);
    if (s == 16'h0000) s = 16'h0001;
    return s;
  endfunction

  for (genvar g = 0; g < NUM_CH; g++) begin : g_draw
    assign seg_ld[g] = CW'(MIN_BOUNCE_CLKS - 1) + CW'(lfsr_q[g][RAND_BITS-1:0]);
    assign nb_ld[g]  = NW'(NUM_BOUNCES_MIN) + NW'(lfsr_q[g][15 -: NB_RAND_BITS]);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    tgt_d    = tgt_q;
    bounce_d = bounce_q;
    for (int i = 0; i < NUM_CH; i++) begin
      lfsr_d[i] = {lfsr_q[i][14:0],
                   lfsr_q[i][15] ^ lfsr_q[i][13] ^ lfsr_q[i][12] ^ lfsr_q[i][10]};
      case (state_q[i])
        ST_INIT: begin
          // Adopt the input level silently so a high input at reset does not bounce.
          bounce_d[i] = bg.sig_in[i];
          state_d[i]  = ST_IDLE;
        end
        ST_IDLE: begin
          if (!bg.en) begin
            bounce_d[i] = bg.sig_in[i];
          end else if (bg.sig_in[i] != bounce_q[i]) begin
            tgt_d[i]   = bg.sig_in[i];
            rem_d[i]   = nb_ld[i];
            cnt_d[i]   = seg_ld[i];
            state_d[i] = ST_AWAY;
          end
        end
        ST_AWAY, ST_TOWARD: begin
          if (!bg.en || (bg.sig_in[i] != tgt_q[i])) begin
            // Bypass or input reverted: abandon the bounce, beating counter expiry.
            bounce_d[i] = bg.sig_in[i];
            state_d[i]  = ST_IDLE;
          end else if (cnt_q[i] != '0) begin
            cnt_d[i] = cnt_q[i] - CW'(1);
          end else if (state_q[i] == ST_AWAY) begin
            bounce_d[i] = tgt_q[i];
            rem_d[i]    = rem_q[i] - NW'(1);
            if (rem_q[i] == NW'(1)) begin
              state_d[i] = ST_IDLE;
            end else begin
              cnt_d[i]   = seg_ld[i];
              state_d[i] = ST_TOWARD;
            end
          end else begin
            bounce_d[i] = ~tgt_q[i];
            cnt_d[i]    = seg_ld[i];
            state_d[i]  = ST_AWAY;
          end
        end
        default: begin
          state_d[i] = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= ST_INIT;
        lfsr_q[i]  <= seed_of(i);
        cnt_q[i]   <= '0;
        rem_q[i]   <= '0;
      end
      tgt_q    <= '0;
      bounce_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        lfsr_q[i]  <= lfsr_d[i];
        cnt_q[i]   <= cnt_d[i];
        rem_q[i]   <= rem_d[i];
      end
      tgt_q    <= tgt_d;
      bounce_q <= bounce_d;
    end
  end

  always_comb begin
    busy_w = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      busy_w[i] = (state_q[i] == ST_AWAY) || (state_q[i] == ST_TOWARD);
    end
  end

  assign bg.bounce_out = bounce_q;
  assign bg.busy       = busy_w;

endmodule

// File: tb/tb_bounce_gen_multi.sv
// Purpose : self-checking bench for bounce_gen_multi (2 channels, short segments).
// Latency : n/a.
// Backpressure: n/a; inputs driven on the falling edge, outputs sampled there too.
module tb_bounce_gen_multi;
  localparam int          NCH   = 2;
  localparam int          MINB  = 4;
  localparam int          RB    = 3;
  localparam int          NBMIN = 2;
  localparam int          NBR   = 1;
  localparam logic [15:0] SEED  = 16'hACE1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bounce_gen_multi_if #(.NUM_CH(NCH)) bg_if();

  bounce_gen_multi #(
    .NUM_CH(NCH), .MIN_BOUNCE_CLKS(MINB), .RAND_BITS(RB),
    .NUM_BOUNCES_MIN(NBMIN), .NB_RAND_BITS(NBR), .SEED(SEED)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bg (bg_if)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;   // clocks since reset release == LFSR shift count

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference LFSR: taps 15,13,12,10 as a mask, feedback = parity of tapped bits.
  function automatic logic [15:0] lf_at(input int ch, input int k);
    logic [15:0] x;
    x = SEED + 16'(ch);
    if (x == 16'h0000) x = 16'h0001;
    for (int j = 0; j < k; j++) x = {x[14:0], ^(x & 16'hB400)};
    return x;
  endfunction

  // Expected toggle schedule per channel: edge indices (clock counts) where the output flips.
  int   sch_t  [NCH][8];
  int   sch_n  [NCH];
  int   sch_k0 [NCH];
  logic sch_init [NCH];

  task automatic sched_none(input int ch, input logic init);
    sch_n[ch]    = 0;
    sch_k0[ch]   = 1 << 30;
    sch_init[ch] = init;
  endtask

  task automatic build_sched(input int ch, input int k0, input logic init);
    logic [15:0] v;
    int t, n;
    t = k0;
    v = lf_at(ch, t);
    n = NBMIN + int'(v[15]);
    sch_n[ch]    = 2 * n - 1;
    sch_k0[ch]   = k0;
    sch_init[ch] = init;
    for (int j = 0; j < 2 * n - 1; j++) begin
      v = lf_at(ch, t);
      t = t + MINB + int'(v[RB-1:0]);
      sch_t[ch][j] = t;
    end
  endtask

  // {busy, out} expected at a falling edge where the bench counter reads c.
  function automatic logic [1:0] exp_at(input int ch, input int c);
    int e, tg;
    logic o, b;
    e  = c - 1;
    tg = 0;
    for (int j = 0; j < sch_n[ch]; j++) if (sch_t[ch][j] <= e) tg++;
    o = sch_init[ch] ^ tg[0];
    b = (sch_n[ch] > 0) && (e >= sch_k0[ch]) && (e < sch_t[ch][sch_n[ch]-1]);
    return {b, o};
  endfunction

  int toggles [NCH];
  int diff_cnt;

  task automatic run_sched(input int ncyc);
    logic [NCH-1:0] prev;
    prev     = bg_if.bounce_out;
    diff_cnt = 0;
    for (int ch = 0; ch < NCH; ch++) toggles[ch] = 0;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      for (int ch = 0; ch < NCH; ch++) begin
        check($sformatf("sched_ch%0d_c%0d", ch, cyc),
              8'({bg_if.busy[ch], bg_if.bounce_out[ch]}), 8'(exp_at(ch, cyc)));
        if (bg_if.bounce_out[ch] != prev[ch]) toggles[ch]++;
      end
      if (bg_if.bounce_out[0] != bg_if.bounce_out[1]) diff_cnt++;
      prev = bg_if.bounce_out;
    end
  endtask

  typedef struct {
    logic       en;
    logic [1:0] sig;
    logic [1:0] out;
    logic [1:0] busy;
  } vec_t;

  vec_t vt [10];

  initial begin
    logic [1:0] prev;
    int k0;
    bit found;

    vt[0] = '{1'b0, 2'b11, 2'b11, 2'b00};
    vt[1] = '{1'b0, 2'b01, 2'b01, 2'b00};
    vt[2] = '{1'b0, 2'b01, 2'b01, 2'b00};
    vt[3] = '{1'b0, 2'b11, 2'b11, 2'b00};
    vt[4] = '{1'b0, 2'b11, 2'b11, 2'b00};
    vt[5] = '{1'b0, 2'b01, 2'b01, 2'b00};
    vt[6] = '{1'b0, 2'b01, 2'b01, 2'b00};
    vt[7] = '{1'b0, 2'b00, 2'b00, 2'b00};
    vt[8] = '{1'b1, 2'b00, 2'b00, 2'b00};  // en 0->1 with input == output: no bounce
    vt[9] = '{1'b1, 2'b00, 2'b00, 2'b00};

    // Reset with input high.
    rst = 1'b0;
    bg_if.en = 1'b1;
    bg_if.sig_in = 2'b11;
    #1 rst = 1'b1;
    #1;
    check("rst_out", 8'(bg_if.bounce_out), 8'h00);
    check("rst_busy", 8'(bg_if.busy), 8'h00);
    repeat (3) @(negedge clk);
    check("rst_held_out", 8'(bg_if.bounce_out), 8'h00);
    rst = 1'b0;
    @(negedge clk);
    check("init_out", 8'(bg_if.bounce_out), 8'h03);
    check("init_busy", 8'(bg_if.busy), 8'h00);
    repeat (10) begin
      @(negedge clk);
      check("init_hold", 8'({bg_if.busy, bg_if.bounce_out}), 8'h03);
    end

    // Bypass: channel 1 toggles every 2 clocks, output lags by exactly one clock.
    prev = 2'b11;
    for (int i = 0; i < 10; i++) begin
      bg_if.en     = vt[i].en;
      bg_if.sig_in = vt[i].sig;
      #1 check($sformatf("byp_nolag0_%0d", i), 8'(bg_if.bounce_out), 8'(prev));
      @(negedge clk);
      check($sformatf("byp_out_%0d", i), 8'(bg_if.bounce_out), 8'(vt[i].out));
      check($sformatf("byp_busy_%0d", i), 8'(bg_if.busy), 8'(vt[i].busy));
      prev = vt[i].out;
    end

    // Single edge on channel 0.
    k0 = cyc;
    build_sched(0, k0, 1'b0);
    sched_none(1, 1'b0);
    bg_if.sig_in = 2'b01;
    run_sched(70);
    check("single_edges", 8'(toggles[0]), 8'(sch_n[0]));
    check("single_final", 8'({bg_if.busy, bg_if.bounce_out}), 8'h01);

    // Abort: back to 0 after three clocks.
    bg_if.en = 1'b0;
    bg_if.sig_in = 2'b00;
    @(negedge clk);
    check("abort_clear", 8'({bg_if.busy, bg_if.bounce_out}), 8'h00);
    bg_if.en = 1'b1;
    @(negedge clk);
    bg_if.sig_in = 2'b01;
    repeat (3) begin
      @(negedge clk);
      check("abort_busy", 8'({bg_if.busy[0], bg_if.bounce_out[0]}), 8'h02);
    end
    bg_if.sig_in = 2'b00;
    repeat (6) begin
      @(negedge clk);
      check("abort_drop", 8'({bg_if.busy, bg_if.bounce_out}), 8'h00);
    end

    // en dropped mid-bounce on channel 1.
    bg_if.sig_in = 2'b10;
    repeat (2) begin
      @(negedge clk);
      check("mid_busy", 8'({bg_if.busy[1], bg_if.bounce_out[1]}), 8'h02);
    end
    bg_if.en = 1'b0;
    @(negedge clk);
    check("mid_byp_out", 8'(bg_if.bounce_out), 8'h02);
    check("mid_byp_busy", 8'(bg_if.busy), 8'h00);

    // Simultaneous edges on both channels.
    bg_if.sig_in = 2'b00;
    @(negedge clk);
    check("sim_clear", 8'({bg_if.busy, bg_if.bounce_out}), 8'h00);
    bg_if.en = 1'b1;
    @(negedge clk);
    k0 = cyc;
    build_sched(0, k0, 1'b0);
    build_sched(1, k0, 1'b0);
    bg_if.sig_in = 2'b11;
    run_sched(70);
    check("sim_edges0", 8'(toggles[0]), 8'(sch_n[0]));
    check("sim_edges1", 8'(toggles[1]), 8'(sch_n[1]));
    check("sim_differ", 8'(diff_cnt > 0), 8'h01);

    // Reset asserted while channel 0 is in TOWARD.
    bg_if.en = 1'b0;
    bg_if.sig_in = 2'b00;
    @(negedge clk);
    bg_if.en = 1'b1;
    @(negedge clk);
    bg_if.sig_in = 2'b01;
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      @(negedge clk);
      if (bg_if.bounce_out[0] && bg_if.busy[0]) found = 1'b1;
    end
    check("reach_toward", 8'(found), 8'h01);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_async", 8'({bg_if.busy, bg_if.bounce_out}), 8'h00);
    @(negedge clk);
    check("rst_mid_held", 8'({bg_if.busy, bg_if.bounce_out}), 8'h00);
    rst = 1'b0;
    @(negedge clk);
    check("reinit", 8'({bg_if.busy, bg_if.bounce_out}), 8'h01);
    repeat (20) begin
      @(negedge clk);
      check("post_rst_hold", 8'({bg_if.busy, bg_if.bounce_out}), 8'h01);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bounce_gen_multi.md
# bounce_gen_multi

Synthesizable, multi-channel switch-bounce generator for exercising debouncers in hardware and in simulation. Each channel watches a clean `sig_in` bit. On every change it drives `bounce_out` through a pseudo-random number of glitches of pseudo-random length before settling on the new value. Randomness comes from a per-channel 16-bit LFSR, so runs are repeatable from the seed. The block sits between stimulus (switches, testbench drivers) and the debouncer under test. It can be bypassed at run time.

## Interface
- `NUM_CH`, 4: number of independent channels (1..32).
- `MIN_BOUNCE_CLKS`, 5000: minimum segment length in clocks; must be ≥ 1.
- `RAND_BITS`, 14: random segment extension is 0..2^RAND_BITS−1 clocks (≤ 16).
- `NUM_BOUNCES_MIN`, 2: minimum bounces per transition; must be ≥ 1.
- `NB_RAND_BITS`, 2: extra bounces are 0..2^NB_RAND_BITS−1 (≤ 4).
- `SEED`, 16'hACE1: base LFSR seed.
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `en` in 1: 1 = bounce mode; 0 = registered pass-through.
- `sig_in` in NUM_CH: clean inputs, synchronous to `clk`.
- `bounce_out` out NUM_CH: bouncy outputs, registered.
- `busy` out NUM_CH: 1 while the channel is mid-bounce.

## Operation
- Per-channel LFSR, 16-bit Fibonacci:
  - Shifts left every clock: new bit0 = b15^b13^b12^b10.
  - Reset value is SEED + i (16-bit wrap); a zero result is replaced by 16'h0001.
- Draws are taken in the cycle a segment is loaded:
  - Segment length D = MIN_BOUNCE_CLKS + lfsr[RAND_BITS−1:0].
  - Bounce count N = NUM_BOUNCES_MIN + lfsr[15 −: NB_RAND_BITS].
- Counter width is $clog2(MIN_BOUNCE_CLKS + 2^RAND_BITS) + 1. No arithmetic overflow is allowed.
- Per-channel FSM:
  - **INIT**: entered on reset. First clock after reset release: `bounce_out` ← `sig_in` with no bounce; → IDLE.
  - **IDLE** (`busy`=0): if `en` and `sig_in` ≠ `bounce_out`, latch target T = `sig_in`, load N and D (counter = D−1); → AWAY. `bounce_out` already equals ~T.
  - **AWAY** (`bounce_out` = ~T): when counter reaches 0, `bounce_out` ← T and remaining count decrements.
    - If remaining was 1: → IDLE.
    - Otherwise: load a new D; → TOWARD.
  - **TOWARD** (`bounce_out` = T): when counter reaches 0, `bounce_out` ← ~T; load a new D; → AWAY.
- Abort: in AWAY or TOWARD, if `sig_in` ≠ T, then `bounce_out` ← `sig_in` and the FSM goes to IDLE in that same clock. Abort has priority over counter expiry.
- `en`=0:
  - Every non-INIT channel goes to IDLE and `bounce_out` ← `sig_in` each clock.
  - Any bounce in progress is abandoned immediately.
- A transition produces exactly 2N−1 output edges. The final edge lands on T.
- Channels are fully independent. Simultaneous edges on several channels are each handled in parallel.

## Timing
- Reset (asynchronous, immediate):
  - `bounce_out` = 0, `busy` = 0.
  - FSM = INIT, LFSR = seed, counters = 0.
- IDLE detects the edge in the clock after `sig_in` changes. `busy` rises on that edge.
- Each AWAY and TOWARD segment holds `bounce_out` constant for exactly D clocks.
- Settling latency from the detecting clock is the sum of the 2N−1 segment lengths.
- `busy` falls on the same clock edge as the final `bounce_out` ← T.
- Abort latency is 1 clock after `sig_in` reverts.
- Pass-through latency (`en`=0) is 1 clock.
- `en` changes take effect on the next clock. A 0→1 change never starts a bounce unless `sig_in` ≠ `bounce_out` at that point.

## Test plan
All scenarios use NUM_CH=2, MIN_BOUNCE_CLKS=4, RAND_BITS=3, NUM_BOUNCES_MIN=2, NB_RAND_BITS=1.
- **Reset with input high**: `sig_in`=2'b11 held, `rst` pulsed → `bounce_out`=00 during reset, 11 one clock after release, no further toggles, `busy`=00.
- **Single edge**: ch0 `sig_in` 0→1, then held → 3 or 5 edges on `bounce_out[0]`. Every segment is 4..11 clocks, the output ends at 1, and `busy[0]` falls with the last rising edge. Exact edge times must match a model of the same LFSR.
- **Abort**: ch0 `sig_in` 0→1, back to 0 after 3 clocks → `bounce_out[0]` stays 0 throughout, `busy[0]` is high for 3 clocks then drops.
- **Bypass**: `en`=0, toggle `sig_in[1]` every 2 clocks → `bounce_out[1]` follows with exactly 1 clock of lag. Set `en`=0 mid-bounce → output equals `sig_in` on the next clock and `busy`=0.
- **Simultaneous channels**: both channels 0→1 on the same clock → each shows a legal, independent sequence, and the sequences differ because of the different seeds.
- **Reset mid-bounce**: assert `rst` during TOWARD → `bounce_out`=00 and `busy`=00 immediately, asynchronously. After release, INIT reloads `sig_in` without bouncing.
